cube3: RTL and testbench

- Sequential integer cube unit, the inverse of the team's cube-root block.
- Takes an unsigned WIDTH_A-bit operand and produces its exact cube over several clocks.
- Uses the same start/busy handshake as the cube-root block.
- Sits beside the root block so round-trip checks and table generation (y -> y^3 -> root) need no software help.

---
 rtl/cube3_pkg.sv | 10 +
 rtl/cube3_if.sv | 10 +
 rtl/cube3_mul.sv | 52 +++++
 rtl/cube3.sv | 66 ++++++
 tb/tb_cube3.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/cube3_pkg.sv
// Shared constants for the sequential cube unit: FSM encoding and derived widths.
package cube3_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PASS1 = 2'd1;
    localparam logic [1:0] PASS2 = 2'd2;

    localparam int WIDTH_A_DEF = 4;
    localparam int RES_W       = 3 * WIDTH_A_DEF;
    localparam int CYCLES      = 2 * WIDTH_A_DEF;
endpackage

// File: rtl/cube3_if.sv
// Start/busy handshake bundle shared with the cube-root block.
interface cube3_if #(parameter int WIDTH_A = 4);
    logic [WIDTH_A-1:0]   a_i;
    logic                 start_i;
    logic [3*WIDTH_A-1:0] y_bo;
    logic                 busy_o;

    modport master (output a_i, output start_i, input y_bo, input busy_o);
    modport slave  (input a_i, input start_i, output y_bo, output busy_o);
endinterface

// File: rtl/cube3_mul.sv
// Serial shift-add multiplier, LSB first; the start edge already consumes bit 0,
// so a BW-bit multiplier finishes BW edges after (and including) the start edge.
module mul_shift_add #(
    parameter int AW = 8,
    parameter int BW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output logic           busy_o,
    input  logic [AW-1:0]  a_i,
    input  logic [BW-1:0]  b_i,
    output logic [AW+BW-1:0] y_bo
);
    localparam int PW = AW + BW;
    localparam int CW = $clog2(BW) + 1;

    logic [PW-1:0] mcand, acc, part;
    logic [BW-1:0] mplier;
    logic [CW-1:0] cnt;
    logic          busy;

    assign part   = mplier[0] ? mcand : '0;
    assign busy_o = busy;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            y_bo   <= '0;
        end else if (busy) begin
            if (cnt == CW'(BW - 1)) begin
                y_bo <= acc + part;
                busy <= 1'b0;
            end else begin
                acc    <= acc + part;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end else if (start_i) begin
            mcand  <= PW'(a_i) << 1;
            mplier <= b_i >> 1;
            acc    <= b_i[0] ? PW'(a_i) : '0;
            cnt    <= CW'(1);
            busy   <= 1'b1;
        end
    end
endmodule

// File: rtl/cube3.sv
// Sequential cube: one shared serial multiplier run twice (a*a, then (a*a)*a).
// busy_o spans exactly 2*WIDTH_A edges; y_bo only changes on completion.
module cube3 #(
    parameter int WIDTH_A = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    cube3_if.slave bus
);
    import cube3_pkg::*;

    localparam int RW = 3 * WIDTH_A;

    logic [1:0]         state;
    logic [WIDTH_A-1:0] a_r;
    logic [RW-1:0]      y_r;
    logic               busy_r;

    logic                 mul_start, mul_busy;
    logic [2*WIDTH_A-1:0] mul_a;
    logic [WIDTH_A-1:0]   mul_b;
    logic [RW-1:0]        mul_y;

    // Pass 1 launches on the accepting edge straight from the bus; pass 2 reuses
    // the pass-1 product as multiplicand as soon as the multiplier goes idle.
    assign mul_start = (state == IDLE && bus.start_i) || (state == PASS1 && !mul_busy);
    assign mul_a     = (state == IDLE) ? {{WIDTH_A{1'b0}}, bus.a_i} : mul_y[2*WIDTH_A-1:0];
    assign mul_b     = (state == IDLE) ? bus.a_i : a_r;

    mul_shift_add #(.AW(2*WIDTH_A), .BW(WIDTH_A)) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(mul_start),
        .busy_o (mul_busy),
        .a_i    (mul_a),
        .b_i    (mul_b),
        .y_bo   (mul_y)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            a_r    <= '0;
            y_r    <= '0;
            busy_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    a_r    <= bus.a_i;
                    busy_r <= 1'b1;
                    state  <= PASS1;
                end
                PASS1: if (!mul_busy) state <= PASS2;
                PASS2: if (!mul_busy) begin
                    y_r    <= mul_y;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y_bo   = y_r;
    assign bus.busy_o = busy_r;
endmodule

// File: tb/tb_cube3.sv
// Directed bench for cube3: vector table plus hand sequences for overlap,
// held start, async reset and a root round trip.
module tb_cube3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cube3_if #(.WIDTH_A(4)) bus();
    cube3 #(.WIDTH_A(4)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    typedef struct {
        logic [3:0]  a;
        logic [11:0] y;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge where busy has dropped.
    task automatic run(input logic [3:0] a, input logic [11:0] exp, input string nm);
        int n;
        logic stable;
        logic [11:0] prev;
        prev = bus.y_bo;
        stable = 1'b1;
        bus.a_i = a;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0;
        while (bus.busy_o && n < 40) begin
            n++;
            if (bus.y_bo !== prev) stable = 1'b0;
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, n, 8);
        chk({nm, " y_hold"}, {31'd0, stable}, 1);
        chk({nm, " y"}, {20'd0, bus.y_bo}, {20'd0, exp});
    endtask

    initial begin
        int n, m, r;
        logic stable;
        bus.a_i = '0;
        bus.start_i = 1'b0;
        vecs[0] = '{4'd15, 12'hD2F};
        vecs[1] = '{4'd0,  12'd0};
        vecs[2] = '{4'd1,  12'd1};
        vecs[3] = '{4'd5,  12'h07D};
        vecs[4] = '{4'd2,  12'd8};
        vecs[5] = '{4'd6,  12'd216};

        #1;
        chk("reset busy", {31'd0, bus.busy_o}, 0);
        chk("reset y", {20'd0, bus.y_bo}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-release busy", {31'd0, bus.busy_o}, 0);

        foreach (vecs[i]) run(vecs[i].a, vecs[i].y, $sformatf("vec%0d", i));

        // start pulse and operand change during busy are ignored
        bus.a_i = 4'd3;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0;
        while (bus.busy_o && n < 40) begin
            n++;
            if (n == 3) begin bus.a_i = 4'd9; bus.start_i = 1'b1; end
            if (n == 4) bus.start_i = 1'b0;
            @(negedge clk);
        end
        chk("overlap busy_cycles", n, 8);
        chk("overlap y", {20'd0, bus.y_bo}, 27);
        m = 0;
        repeat (4) begin
            if (bus.busy_o) m++;
            @(negedge clk);
        end
        chk("overlap no rerun", m, 0);

        // held start: 8 busy, 1 idle, repeat
        bus.a_i = 4'd2;
        bus.start_i = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            stable = 1'b1;
            while (bus.busy_o && n < 40) begin
                n++;
                if (k > 0 && bus.y_bo !== 12'd8) stable = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("held run%0d busy", k), n, 8);
            chk($sformatf("held run%0d y_hold", k), {31'd0, stable}, 1);
            m = 0;
            while (!bus.busy_o && m < 5) begin
                m++;
                if (bus.y_bo !== 12'd8) stable = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("held run%0d idle", k), m, 1);
            chk($sformatf("held run%0d y", k), {31'd0, stable}, 1);
        end
        bus.start_i = 1'b0;
        n = 0;
        while (bus.busy_o && n < 40) begin n++; @(negedge clk); end
        chk("held tail y", {20'd0, bus.y_bo}, 8);

        // asynchronous reset mid-run
        bus.a_i = 4'd7;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, bus.busy_o}, 0);
        chk("abort y", {20'd0, bus.y_bo}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(4'd4, 12'd64, "after_reset");

        // round trip through an integer cube root
        for (int a = 0; a <= 6; a++) begin
            run(4'(a), 12'(a * a * a), $sformatf("rt%0d", a));
            r = 0;
            while ((r + 1) * (r + 1) * (r + 1) <= int'(bus.y_bo) && r < 16) r++;
            chk($sformatf("rt%0d root", a), r, a);
            chk($sformatf("rt%0d idle", a), {31'd0, bus.busy_o}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
